fetch_unit: RTL

Instruction fetch stage of the single-cycle ARM (LEGv8) processor with exceptions; sits directly upstream of signext and the decoder.
- Holds the PC and fetches 32-bit instructions from instruction memory over a req/ack handshake.
- Presents each instruction, with its PC, to the decode side under a valid/ready handshake.
- Applies branch and exception redirects, and raises a fault on misaligned fetch targets.

---
 rtl/fetch_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over req/ack,
// hands instr/instr_pc to decode under valid/ready, applies redirects.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   imem_req/addr         fetch request and address to instruction memory
//   imem_ack/rdata        memory response (sampled only while requesting)
//   instr/instr_pc        registered instruction and its PC
//   instr_valid/ready     decode-side handshake
//   branch_en/target      branch redirect
//   exc_en                exception redirect to EXC_VECTOR (wins over branch)
//   fetch_fault           one-cycle pulse on a misaligned branch target
module fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [63:0] EXC_VECTOR = 64'hD8
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_en,
  input  logic [63:0] branch_target,
  input  logic        exc_en,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN,
    HOLD
  } state_t;

  state_t      state, state_nx;
  logic [63:0] pc, pc_nx;
  logic [63:0] held, held_nx;
  logic [31:0] instr_nx;
  logic [63:0] instr_pc_nx;
  logic        valid_nx;
  logic        fault_nx;

  logic        redir;
  logic        misal;
  logic [63:0] tgt;

  assign redir = exc_en | branch_en;
  assign misal = branch_target[1:0] != 2'b00;

  // A misaligned branch is steered to the handler instead.
  always_comb begin
    tgt = branch_target;
    if (exc_en || misal)
      tgt = EXC_VECTOR;
  end

  assign imem_req  = (state == REQ) || (state == DRAIN);
  assign imem_addr = (state == DRAIN) ? held : pc;

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    held_nx     = held;
    instr_nx    = instr;
    instr_pc_nx = instr_pc;
    valid_nx    = instr_valid;
    // Every state but IDLE acts on a redirect.
    fault_nx    = (state != IDLE) && !exc_en
                  && branch_en && misal;
    unique case (state)
      IDLE: state_nx = REQ;
      REQ: begin
        if (redir) begin
          pc_nx = tgt;
          if (!imem_ack) begin
            // Old request is still in flight; keep its address
            // on the bus until memory answers it.
            held_nx  = pc;
            state_nx = DRAIN;
          end
        end else if (imem_ack) begin
          instr_nx    = imem_rdata;
          instr_pc_nx = pc;
          valid_nx    = 1'b1;
          pc_nx       = pc + 64'd4;
          state_nx    = HOLD;
        end
      end
      DRAIN: begin
        if (redir)
          pc_nx = tgt;
        if (imem_ack)
          state_nx = REQ;
      end
      HOLD: begin
        if (redir) begin
          valid_nx = 1'b0;
          pc_nx    = tgt;
          state_nx = REQ;
        end else if (instr_ready) begin
          valid_nx = 1'b0;
          state_nx = REQ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      held        <= RESET_PC;
      instr       <= 32'h0;
      instr_pc    <= 64'h0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      held        <= held_nx;
      instr       <= instr_nx;
      instr_pc    <= instr_pc_nx;
      instr_valid <= valid_nx;
      fetch_fault <= fault_nx;
    end
  end

endmodule
